// File: rtl/rtc_event_stamp_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rtc_pkg : shared types and constants for the RTC event time-stamper      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package rtc_pkg;

    localparam logic [31:0] NSEC_PER_SEC = 32'd1000000000;
    localparam int          SYNC_STAGES  = 2;

    typedef struct packed {
        logic [31:0] sec;
        logic [31:0] nsec;
        logic [7:0]  seq;
    } stamp_t;

    // Moves a time back by comp nanoseconds; comp is always well below one second.
    // Seconds borrow wraps naturally, so 0 becomes 0xFFFFFFFF.
    function automatic stamp_t sub_latency(
        input logic [31:0] sec,
        input logic [31:0] nsec,
        input logic [31:0] comp,
        input logic [7:0]  seq
    );
        stamp_t r;
        r.seq = seq;
        if (nsec >= comp) begin
            r.sec  = sec;
            r.nsec = nsec - comp;
        end else begin
            r.sec  = sec - 32'd1;
            r.nsec = nsec + NSEC_PER_SEC - comp;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rtc_event_stamp_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rtc_event_stamp_if : stamp output stream (valid/ready with stamp fields)  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface rtc_event_stamp_if;

    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_sec;
    logic [31:0] m_nsec;
    logic [7:0]  m_seq;

    modport master (
        output m_valid,
        output m_sec,
        output m_nsec,
        output m_seq,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_sec,
        input  m_nsec,
        input  m_seq,
        output m_ready
    );

endinterface
`default_nettype wire

// File: rtl/rtc_event_stamp_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rtc_stamp_fifo : synchronous first-word-fall-through FIFO with level     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module rtc_stamp_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 72
) (
    input  wire logic                       clk,
    input  wire logic                       rst_n,
    input  wire logic                       i_push,
    input  wire logic [WIDTH-1:0]           i_data,
    input  wire logic                       i_pop,
    output logic      [WIDTH-1:0]           o_data,
    output logic                            o_valid,
    output logic                            o_full,
    output logic      [$clog2(DEPTH):0]     o_level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [AW:0]      w_level;
    logic             w_empty;
    logic             w_rd;
    logic             w_wr;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_level = r_wr_ptr - r_rd_ptr;
    assign w_empty = (w_level == '0);
    assign o_full  = (w_level == (AW+1)'(DEPTH));
    assign w_rd    = i_pop & ~w_empty;
    assign w_wr    = i_push & (~o_full | w_rd);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

    assign o_valid = ~w_empty;
    assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    assign o_level = w_level;

endmodule
`default_nettype wire

// File: rtl/rtc_event_stamp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rtc_event_stamp : time-stamps rising edges of an async event into a FIFO |
// | Optional: RTC_STAMP_LATENCY_COMP_EN subtracts 3 clock periods. Rev 1.0   |
// +--------------------------------------------------------------------------+
module rtc_event_stamp
    import rtc_pkg::*;
#(
    parameter int DEPTH           = 16,
    parameter int CLOCK_PERIOD_NS = 8
) (
    input  wire logic                   aclk,
    input  wire logic                   aresetn,
    input  wire logic                   evt_in,
    input  wire logic [31:0]            rtc_sec,
    input  wire logic [31:0]            rtc_nsec,
    rtc_event_stamp_if.master           m_if,
    output logic [$clog2(DEPTH):0]      stat_level,
    output logic                        stat_overflow,
    output logic [15:0]                 stat_drop_cnt,
    input  wire logic                   ctrl_clr
);

    localparam int STAMP_W = $bits(stamp_t);

    // Compensation of zero leaves the captured time untouched.
`ifdef RTC_STAMP_LATENCY_COMP_EN
    localparam logic [31:0] COMP_NS = 32'(3 * CLOCK_PERIOD_NS);
`else
    localparam logic [31:0] COMP_NS = 32'(0 * CLOCK_PERIOD_NS);
`endif

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_evt_d;
    logic                   w_detect;
    logic [7:0]             r_seq;
    stamp_t                 r_cap;
    logic                   r_cap_vld;
    logic [STAMP_W-1:0]     w_head_bits;
    stamp_t                 w_head;
    logic                   w_head_vld;
    logic                   w_full;
    logic                   w_pop;
    logic                   w_drop;
    logic                   r_overflow;
    logic [15:0]            r_drop_cnt;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_sync  <= '0;
            r_evt_d <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], evt_in};
            r_evt_d <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_detect = r_sync[SYNC_STAGES-1] & ~r_evt_d;

    // Compensation is folded into the capture register so write latency is fixed.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_seq     <= '0;
            r_cap     <= '0;
            r_cap_vld <= 1'b0;
        end else begin
            r_cap_vld <= w_detect;
            if (w_detect) begin
                r_cap <= sub_latency(rtc_sec, rtc_nsec, COMP_NS, r_seq);
                r_seq <= r_seq + 8'd1;
            end
        end
    end

    assign w_pop  = w_head_vld & m_if.m_ready;
    assign w_drop = r_cap_vld & w_full & ~w_pop;

    rtc_stamp_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (STAMP_W)
    ) u_fifo (
        .clk     (aclk),
        .rst_n   (aresetn),
        .i_push  (r_cap_vld),
        .i_data  (r_cap),
        .i_pop   (w_pop),
        .o_data  (w_head_bits),
        .o_valid (w_head_vld),
        .o_full  (w_full),
        .o_level (stat_level)
    );

    // A clear lands before a same-cycle drop, leaving flag=1 and count=1.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (ctrl_clr) begin
            r_overflow <= w_drop;
            r_drop_cnt <= {15'd0, w_drop};
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign w_head          = stamp_t'(w_head_bits);
    assign m_if.m_valid    = w_head_vld;
    assign m_if.m_sec      = w_head.sec;
    assign m_if.m_nsec     = w_head.nsec;
    assign m_if.m_seq      = w_head.seq;
    assign stat_overflow   = r_overflow;
    assign stat_drop_cnt   = r_drop_cnt;

endmodule
`default_nettype wire
